// File: rtl/infix_to_postfix_pkg.sv
// Shared calculator definitions: token classes, opcodes, precedence and number-field positions.
// Also used by the postfix evaluator, so some fields are not referenced by the converter.
package calc_pkg;

    typedef enum logic [1:0] {
        TK_NUM    = 2'b00,
        TK_OP     = 2'b01,
        TK_LPAREN = 2'b10,
        TK_SEP    = 2'b11
    } tok_class_t;

    typedef enum logic [3:0] {
        S_IDLE, S_READ, S_POP_PREC, S_POP_PAREN, S_FUNC_CHK,
        S_POP_COMMA, S_FLUSH, S_DONE, S_ERR
    } conv_state_t;

    localparam logic [7:0] OP_ADD     = 8'h2A;
    localparam logic [7:0] OP_SUB     = 8'h2B;
    localparam logic [7:0] OP_MUL     = 8'h2C;
    localparam logic [7:0] OP_DIV     = 8'h2D;
    localparam logic [7:0] FN_EXP     = 8'hF0;
    localparam logic [7:0] FN_LN      = 8'hF1;
    localparam logic [7:0] FN_POW     = 8'hF2;
    localparam logic [7:0] FN_LOG     = 8'hF3;
    localparam logic [7:0] FN_SIN     = 8'hF4;
    localparam logic [7:0] FN_COS     = 8'hF5;
    localparam logic [7:0] FN_TAN     = 8'hF6;
    localparam logic [7:0] SEP_RPAREN = 8'h29;
    localparam logic [7:0] SEP_COMMA  = 8'h2C;

    localparam int CLASS_MSB = 43;
    localparam int CLASS_LSB = 42;
    localparam int SIGN_BIT  = 41;
    localparam int MANT_MSB  = 40;
    localparam int MANT_LSB  = 7;
    localparam int EXP_MSB   = 6;
    localparam int EXP_LSB   = 0;

    function automatic logic isFunc(input logic [7:0] op);
        return (op >= FN_EXP) && (op <= FN_TAN);
    endfunction

    function automatic logic [1:0] prec(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB: prec = 2'd1;
            OP_MUL, OP_DIV: prec = 2'd2;
            default:        prec = isFunc(op) ? 2'd3 : 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/infix_to_postfix_if.sv
// Token-array bus between the infix producer, the converter and the postfix evaluator.
interface infix_to_postfix_if #(
    parameter int depth    = 10,
    parameter int newWidth = 44
);
    localparam int SW = $clog2(depth + 1);

    logic                start;
    logic [SW-1:0]       infixSize;
    logic [newWidth-1:0] infix [depth];
    logic [newWidth-1:0] postfix [depth];
    logic [SW-1:0]       postfixSize;
    logic                conv;
    logic                error;

    modport master (
        output start, infixSize, infix,
        input  postfix, postfixSize, conv, error
    );

    modport slave (
        input  start, infixSize, infix,
        output postfix, postfixSize, conv, error
    );
endinterface

// File: rtl/infix_to_postfix_op_stack.sv
// Operator LIFO for the shunting-yard converter; overflowing pushes and empty pops are dropped.
module op_stack #(
    parameter int depth = 10,
    parameter int width = 44
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [width-1:0]             pushData,
    output logic [width-1:0]             top,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int CW = $clog2(depth + 1);
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;

    logic [width-1:0] mem [depth];
    logic [CW-1:0]    topIdx;

    assign empty  = (count == '0);
    assign full   = (count == CW'(depth));
    assign topIdx = count - 1'b1;
    assign top    = empty ? '0 : mem[topIdx[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear && push && !full)
            mem[count[AW-1:0]] <= pushData;
    end
endmodule

// File: rtl/infix_to_postfix.sv
// Shunting-yard infix-to-postfix converter feeding the postfix evaluator.
// Optional INFIX_ERR_CHECK_EN routes overflow / unbalanced parentheses to S_ERR.
//
// state       | meaning
// S_IDLE      | waiting for a start rising edge
// S_READ      | dispatch the next infix token
// S_POP_PREC  | pop higher/equal precedence ops, then push the binary op
// S_POP_PAREN | pop until '(' on ')'
// S_FUNC_CHK  | emit the function owning the closed '(' if there is one
// S_POP_COMMA | pop until '(' on ','
// S_FLUSH     | drain the stack to the output
// S_DONE      | publish postfixSize and pulse conv
// S_ERR       | flag error, no conv
module infix_to_postfix
    import calc_pkg::*;
#(
    parameter int depth    = 10,
    parameter int newWidth = 44
) (
    input logic             clock,
    input logic             reset,
    infix_to_postfix_if.slave bus
);
    localparam int SW = $clog2(depth + 1);
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;

    conv_state_t         state;
    logic [SW-1:0]       inIdx;
    logic [SW-1:0]       outIdx;
    logic                startQ;
    logic                startEdge;

    logic [newWidth-1:0] tok;
    tok_class_t          tokClass;
    logic [7:0]          tokOp;

    logic [newWidth-1:0] stkTop;
    logic [SW-1:0]       stkCount;
    logic                stkEmpty, stkFull;
    logic                stkPush, stkPop, stkClear;
    tok_class_t          topClass;
    logic [7:0]          topOp;

    logic                popPrec;
    logic                outWr;
    logic [newWidth-1:0] outData;

    assign startEdge = bus.start && !startQ;
    assign stkClear  = (state == S_IDLE) && startEdge;
    assign tok       = (inIdx < SW'(depth)) ? bus.infix[inIdx[AW-1:0]] : '0;
    assign tokClass  = tok_class_t'(tok[CLASS_MSB:CLASS_LSB]);
    assign tokOp     = tok[7:0];
    assign topClass  = tok_class_t'(stkTop[CLASS_MSB:CLASS_LSB]);
    assign topOp     = stkTop[7:0];
    assign popPrec   = !stkEmpty && (topClass != TK_LPAREN) && (prec(topOp) >= prec(tokOp));

    op_stack #(.depth(depth), .width(newWidth)) u_stack (
        .clock    (clock),
        .reset    (reset),
        .clear    (stkClear),
        .push     (stkPush),
        .pop      (stkPop),
        .pushData (tok),
        .top      (stkTop),
        .count    (stkCount),
        .empty    (stkEmpty),
        .full     (stkFull)
    );

    // Stack and output-write strobes for the current state; the FSM below only sequences.
    always_comb begin
        stkPush = 1'b0;
        stkPop  = 1'b0;
        outWr   = 1'b0;
        outData = tok;
        case (state)
            S_READ: begin
                if (inIdx < bus.infixSize) begin
                    case (tokClass)
                        TK_NUM:    outWr   = 1'b1;
                        TK_OP:     stkPush = isFunc(tokOp);
                        TK_LPAREN: stkPush = 1'b1;
                        default:   ;
                    endcase
                end
            end
            S_POP_PREC: begin
                if (popPrec) begin
                    stkPop  = 1'b1;
                    outWr   = 1'b1;
                    outData = stkTop;
                end else begin
                    stkPush = 1'b1;
                end
            end
            S_POP_PAREN, S_FLUSH: begin
                if (!stkEmpty) begin
                    stkPop  = 1'b1;
                    outWr   = (topClass != TK_LPAREN);
                    outData = stkTop;
                end
            end
            S_FUNC_CHK: begin
                if ((stkCount != '0) && (topClass == TK_OP) && isFunc(topOp)) begin
                    stkPop  = 1'b1;
                    outWr   = 1'b1;
                    outData = stkTop;
                end
            end
            S_POP_COMMA: begin
                if (!stkEmpty && (topClass != TK_LPAREN)) begin
                    stkPop  = 1'b1;
                    outWr   = 1'b1;
                    outData = stkTop;
                end
            end
            default: ;
        endcase
    end

`ifdef INFIX_ERR_CHECK_EN
    logic errorQ;
    logic errHit;
    assign errHit = (outWr && (outIdx >= SW'(depth)))
                 || (stkPush && stkFull)
                 || (stkEmpty && ((state == S_POP_PAREN) || (state == S_POP_COMMA)))
                 || ((state == S_FLUSH) && !stkEmpty && (topClass == TK_LPAREN));
    assign bus.error = errorQ;
`else
    assign bus.error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            inIdx           <= '0;
            outIdx          <= '0;
            startQ          <= 1'b0;
            bus.postfixSize <= '0;
            bus.conv        <= 1'b0;
            for (int i = 0; i < depth; i++)
                bus.postfix[i] <= '0;
`ifdef INFIX_ERR_CHECK_EN
            errorQ          <= 1'b0;
`endif
        end else begin
            startQ   <= bus.start;
            bus.conv <= 1'b0;
            if (outWr && (outIdx < SW'(depth))) begin
                bus.postfix[outIdx[AW-1:0]] <= outData;
                outIdx <= outIdx + 1'b1;
            end
`ifdef INFIX_ERR_CHECK_EN
            if (errHit)
                state <= S_ERR;
            else
`endif
            case (state)
                S_IDLE: begin
                    if (startEdge) begin
                        inIdx  <= '0;
                        outIdx <= '0;
`ifdef INFIX_ERR_CHECK_EN
                        errorQ <= 1'b0;
`endif
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    if (inIdx >= bus.infixSize) begin
                        state <= S_FLUSH;
                    end else begin
                        case (tokClass)
                            TK_NUM, TK_LPAREN: inIdx <= inIdx + 1'b1;
                            TK_OP: begin
                                if (isFunc(tokOp))
                                    inIdx <= inIdx + 1'b1;
                                else
                                    state <= S_POP_PREC;
                            end
                            default: state <= (tokOp == SEP_RPAREN) ? S_POP_PAREN : S_POP_COMMA;
                        endcase
                    end
                end
                S_POP_PREC: begin
                    if (!popPrec) begin
                        inIdx <= inIdx + 1'b1;
                        state <= S_READ;
                    end
                end
                S_POP_PAREN: begin
                    // An empty stack here is a stray ')', consumed without effect.
                    if (stkEmpty) begin
                        inIdx <= inIdx + 1'b1;
                        state <= S_READ;
                    end else if (topClass == TK_LPAREN) begin
                        state <= S_FUNC_CHK;
                    end
                end
                S_FUNC_CHK: begin
                    inIdx <= inIdx + 1'b1;
                    state <= S_READ;
                end
                S_POP_COMMA: begin
                    if (stkEmpty || (topClass == TK_LPAREN)) begin
                        inIdx <= inIdx + 1'b1;
                        state <= S_READ;
                    end
                end
                S_FLUSH: begin
                    if (stkEmpty)
                        state <= S_DONE;
                end
                S_DONE: begin
                    bus.postfixSize <= outIdx;
                    bus.conv        <= 1'b1;
                    state           <= S_IDLE;
                end
                S_ERR: begin
`ifdef INFIX_ERR_CHECK_EN
                    errorQ <= 1'b1;
`endif
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_infix_to_postfix.sv
// Bench for infix_to_postfix: directed cases plus random expressions whose postfix
// form is derived algebraically from the expression shape.
module tb_infix_to_postfix;
    import calc_pkg::*;

    localparam int DEPTH = 10;
    localparam int W     = 44;

    logic clock = 1'b0;
    logic reset = 1'b0;

    infix_to_postfix_if #(.depth(DEPTH), .newWidth(W)) bus ();

    infix_to_postfix #(.depth(DEPTH), .newWidth(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nFail   = 0;

    logic [W-1:0] inTok[$];
    logic [W-1:0] expTok[$];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] numTok(input logic [33:0] m);
        return {2'b00, 1'b0, m, 7'd0};
    endfunction
    function automatic logic [W-1:0] rndNum();
        return {2'b00, 10'($urandom), 32'($urandom)};
    endfunction
    function automatic logic [W-1:0] opTok(input logic [7:0] op);
        return {2'b01, 34'd0, op};
    endfunction
    function automatic logic [W-1:0] lpTok();
        return {2'b10, 42'd0};
    endfunction
    function automatic logic [W-1:0] sepTok(input logic [7:0] c);
        return {2'b11, 34'd0, c};
    endfunction
    function automatic logic [W-1:0] rndBin();
        return opTok(8'h2A + 8'($urandom_range(0, 3)));
    endfunction

    task automatic runConv(input string tag, input bit expectOk);
        int pulses = 0;
        int n = inTok.size();
        bus.start = 1'b0;
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++)
            bus.infix[i] = (i < n) ? inTok[i] : '0;
        bus.infixSize = 4'(n);
        bus.start = 1'b1;
        for (int c = 0; c < 3 * n + 8; c++) begin
            @(negedge clock);
            if (bus.conv) pulses++;
        end
        bus.start = 1'b0;
        if (expectOk) begin
            checkVal({tag, "/convPulses"}, 64'(pulses), 64'd1);
            checkVal({tag, "/error"}, 64'(bus.error), 64'd0);
            checkVal({tag, "/size"}, 64'(bus.postfixSize), 64'(expTok.size()));
            for (int i = 0; i < expTok.size(); i++)
                checkVal($sformatf("%s/postfix[%0d]", tag, i), 64'(bus.postfix[i]), 64'(expTok[i]));
        end else begin
            checkVal({tag, "/convPulses"}, 64'(pulses), 64'd0);
            checkVal({tag, "/error"}, 64'(bus.error), 64'd1);
        end
    endtask

    // Random expression from a handful of shapes; postfix written from the algebra of each shape.
    task automatic genRandom();
        logic [W-1:0] v[5];
        logic [W-1:0] o[4];
        logic [W-1:0] term[$];
        logic [W-1:0] pendOp;
        logic [W-1:0] f;
        bit pend;
        int n;
        inTok.delete();
        expTok.delete();
        for (int i = 0; i < 5; i++) v[i] = rndNum();
        for (int i = 0; i < 4; i++) o[i] = rndBin();
        case ($urandom_range(0, 6))
            0: begin
                n = $urandom_range(2, 5);
                inTok.push_back(v[0]);
                for (int i = 0; i < n - 1; i++) begin
                    inTok.push_back(o[i]);
                    inTok.push_back(v[i+1]);
                end
                // Multiplicative runs form terms; terms combine left to right.
                term = '{v[0]};
                pend = 1'b0;
                pendOp = '0;
                for (int i = 0; i < n - 1; i++) begin
                    if (o[i][7:0] >= 8'h2C) begin
                        term.push_back(v[i+1]);
                        term.push_back(o[i]);
                    end else begin
                        foreach (term[k]) expTok.push_back(term[k]);
                        if (pend) expTok.push_back(pendOp);
                        pendOp = o[i];
                        pend = 1'b1;
                        term = '{v[i+1]};
                    end
                end
                foreach (term[k]) expTok.push_back(term[k]);
                if (pend) expTok.push_back(pendOp);
            end
            1: begin
                inTok  = '{lpTok(), v[0], o[0], v[1], sepTok(8'h29), o[1], v[2]};
                expTok = '{v[0], v[1], o[0], v[2], o[1]};
            end
            2: begin
                inTok  = '{v[0], o[0], lpTok(), v[1], o[1], v[2], sepTok(8'h29)};
                expTok = '{v[0], v[1], v[2], o[1], o[0]};
            end
            3: begin
                case ($urandom_range(0, 4))
                    0: f = opTok(8'hF0);
                    1: f = opTok(8'hF1);
                    2: f = opTok(8'hF4);
                    3: f = opTok(8'hF5);
                    default: f = opTok(8'hF6);
                endcase
                inTok  = '{f, lpTok(), v[0], o[0], v[1], sepTok(8'h29), o[1], v[2]};
                expTok = '{v[0], v[1], o[0], f, v[2], o[1]};
            end
            4: begin
                f = opTok($urandom_range(0, 1) == 0 ? 8'hF2 : 8'hF3);
                inTok  = '{v[2], o[1], f, lpTok(), v[0], sepTok(8'h2C), v[1], sepTok(8'h29)};
                expTok = '{v[2], v[0], v[1], f, o[1]};
            end
            5: ;
            default: begin
                inTok  = '{v[0]};
                expTok = '{v[0]};
            end
        endcase
    endtask

    initial begin
        int waited;
        int pulses;
        bus.start = 1'b0;
        bus.infixSize = '0;
        for (int i = 0; i < DEPTH; i++) bus.infix[i] = '0;

        #12;
        checkVal("reset/conv", 64'(bus.conv), 64'd0);
        checkVal("reset/size", 64'(bus.postfixSize), 64'd0);
        checkVal("reset/error", 64'(bus.error), 64'd0);
        checkVal("reset/postfix0", 64'(bus.postfix[0]), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        inTok  = '{numTok(3), opTok(8'h2A), numTok(4), opTok(8'h2C), numTok(5)};
        expTok = '{numTok(3), numTok(4), numTok(5), opTok(8'h2C), opTok(8'h2A)};
        runConv("3+4*5", 1'b1);

        inTok  = '{lpTok(), numTok(3), opTok(8'h2A), numTok(4), sepTok(8'h29), opTok(8'h2C), numTok(5)};
        expTok = '{numTok(3), numTok(4), opTok(8'h2A), numTok(5), opTok(8'h2C)};
        runConv("(3+4)*5", 1'b1);

        inTok  = '{opTok(8'hF2), lpTok(), numTok(2), sepTok(8'h2C), numTok(3), sepTok(8'h29),
                   opTok(8'h2B), numTok(1)};
        expTok = '{numTok(2), numTok(3), opTok(8'hF2), numTok(1), opTok(8'h2B)};
        runConv("pow(2,3)-1", 1'b1);

        inTok  = '{numTok(8), opTok(8'h2B), numTok(3), opTok(8'h2B), numTok(2)};
        expTok = '{numTok(8), numTok(3), opTok(8'h2B), numTok(2), opTok(8'h2B)};
        runConv("8-3-2", 1'b1);

        inTok.delete();
        expTok.delete();
        runConv("empty", 1'b1);

        inTok  = '{lpTok(), lpTok(), numTok(3)};
        expTok = '{numTok(3)};
`ifdef INFIX_ERR_CHECK_EN
        runConv("((3", 1'b0);
`else
        runConv("((3", 1'b1);
`endif

        // Reset while draining the stack.
        inTok = '{numTok(1), opTok(8'h2A), numTok(2), opTok(8'h2C), numTok(3)};
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++)
            bus.infix[i] = (i < inTok.size()) ? inTok[i] : '0;
        bus.infixSize = 4'(inTok.size());
        bus.start = 1'b1;
        waited = 0;
        pulses = 0;
        while (dut.state != S_FLUSH && waited < 40) begin
            @(negedge clock);
            if (bus.conv) pulses++;
            waited++;
        end
        checkVal("midReset/reachedFlush", 64'(waited < 40), 64'd1);
        reset = 1'b0;
        #1;
        checkVal("midReset/conv", 64'(bus.conv), 64'd0);
        checkVal("midReset/size", 64'(bus.postfixSize), 64'd0);
        checkVal("midReset/postfix0", 64'(bus.postfix[0]), 64'd0);
        checkVal("midReset/idle", 64'(dut.state == S_IDLE), 64'd1);
        bus.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (bus.conv) pulses++;
        end
        checkVal("midReset/noConv", 64'(pulses), 64'd0);
        reset = 1'b1;
        expTok = '{numTok(1), numTok(2), numTok(3), opTok(8'h2C), opTok(8'h2A)};
        runConv("afterReset", 1'b1);

        for (int r = 0; r < 40; r++) begin
            genRandom();
            runConv($sformatf("rand%0d", r), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
